// File: rtl/rv32_ahb_sram_slave_pkg.sv
// rv32_ahb_sram_slave_pkg: AHB-Lite encodings and SRAM slave state type
package rv32_ahb_sram_slave_pkg;
    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_BUSY   = 2'b01;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_SEQ    = 2'b11;
    localparam logic [2:0] AHB_SIZE_BYTE = 3'd0;
    localparam logic [2:0] AHB_SIZE_HALF = 3'd1;
    localparam logic [2:0] AHB_SIZE_WORD = 3'd2;
    localparam logic AHB_RESP_OKAY  = 1'b0;
    localparam logic AHB_RESP_ERROR = 1'b1;
    typedef enum logic [2:0] {IDLE, RD, RD_LATE, WR, ERR1, ERR2} ahb_sram_state_e;
endpackage

// File: rtl/rv32_ahb_byte_lane.sv
// rv32_ahb_byte_lane: little-endian byte enables and size/alignment legality for an AHB transfer
module rv32_ahb_byte_lane
    import rv32_ahb_sram_slave_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    output logic [3:0] be,
    output logic       misaligned,
    output logic       size_illegal
);
    always_comb begin
        be = (hsize == AHB_SIZE_BYTE) ? 4'b0001 << addr :
             (hsize == AHB_SIZE_HALF) ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        misaligned = (hsize == AHB_SIZE_HALF && addr[0]) ||
                     (hsize == AHB_SIZE_WORD && addr != 2'b00);
        size_illegal = hsize > AHB_SIZE_WORD;
    end
endmodule

// File: rtl/rv32_ahb_sram_slave.sv
// rv32_ahb_sram_slave: AHB-Lite slave driving a single-port synchronous SRAM
module rv32_ahb_sram_slave
    import rv32_ahb_sram_slave_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);
    localparam logic [1:0] WS_CNT = 2'(WAIT_STATES);
    localparam logic [1:0] RL_CNT = (WAIT_STATES == 0) ? 2'd1 : WS_CNT;

    ahb_sram_state_e   state, state_nx;
    logic [1:0]        cnt, cnt_nx;
    logic              first;
    logic [ADDR_W-1:0] dp_addr;
    logic [3:0]        dp_be;
    logic [31:0]       hrdata_q;
    logic [3:0]        lane_be;
    logic              misaligned, size_illegal;
    logic              acc, illegal, rd_fast, wr_now, rd_issue, rd_live;

    rv32_ahb_byte_lane u_lane (
        .hsize        (HSIZE),
        .addr         (HADDR[1:0]),
        .be           (lane_be),
        .misaligned   (misaligned),
        .size_illegal (size_illegal)
    );

    always_comb begin
        acc = HSEL && HREADY && (HTRANS == AHB_NONSEQ || HTRANS == AHB_SEQ);
        illegal = size_illegal || misaligned ||
                  (HADDR[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
        HREADYOUT = (state == ERR1) ? 1'b0 :
                    (state == WR || state == RD_LATE) ? (cnt == 2'd0) : 1'b1;
        HRESP = (state == ERR1 || state == ERR2) ? AHB_RESP_ERROR : AHB_RESP_OKAY;
        // A write occupies the SRAM port in its final cycle, so a read accepted then must go late
        rd_fast = acc && HREADYOUT && !HWRITE && !illegal && WAIT_STATES == 0 && state != WR;
        wr_now = state == WR && cnt == 2'd0;
        rd_issue = state == RD_LATE && first;
        rd_live = state == RD || (state == RD_LATE && !first);
        sram_ce = !rst && (wr_now || rd_issue || rd_fast);
        sram_we = !rst && wr_now;
        sram_be = (!rst && wr_now) ? dp_be : 4'b0000;
        sram_addr = rd_fast ? HADDR[ADDR_W+1:2] : dp_addr;
        sram_wdata = HWDATA;
        HRDATA = rd_live ? sram_rdata : hrdata_q;
        state_nx = IDLE;
        cnt_nx = 2'd0;
        if (!HREADYOUT) begin
            state_nx = (state == ERR1) ? ERR2 : state;
            cnt_nx = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        end else if (acc) begin
            state_nx = illegal ? ERR1 : HWRITE ? WR : rd_fast ? RD : RD_LATE;
            cnt_nx = illegal ? 2'd0 : HWRITE ? WS_CNT : rd_fast ? 2'd0 : RL_CNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            first    <= 1'b0;
            hrdata_q <= 32'h0;
            dp_addr  <= '0;
            dp_be    <= 4'b0000;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            first <= HREADYOUT && state_nx == RD_LATE;
            if (rd_live)
                hrdata_q <= sram_rdata;
            if (HREADYOUT && acc) begin
                dp_addr <= HADDR[ADDR_W+1:2];
                dp_be   <= lane_be;
            end
        end
    end
endmodule

// File: tb/tb_rv32_ahb_sram_slave.sv
// tb_rv32_ahb_sram_slave: scoreboard bench for the AHB SRAM slave at zero and two wait states
module tb_rv32_ahb_sram_slave;
    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
    } item_t;
    typedef struct {
        logic        write;
        logic        resp;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel [2];
    logic [31:0] haddr [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize [2];
    logic [31:0] hwdata [2];
    logic        hreadyout [2];
    logic        hresp [2];
    logic [31:0] hrdata [2];
    logic        sram_ce [2];
    logic        sram_we [2];
    logic [3:0]  sram_be [2];
    logic [13:0] sram_addr [2];
    logic [31:0] sram_wdata [2];
    logic [31:0] sram_rdata [2];
    logic [31:0] mem [2][16384];
    logic [31:0] ref_w [2][16384];
    item_t       seq [$];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    rv32_ahb_sram_slave #(.ADDR_W(14), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hreadyout[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]),
        .sram_ce(sram_ce[0]), .sram_we(sram_we[0]), .sram_be(sram_be[0]),
        .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0])
    );

    rv32_ahb_sram_slave #(.ADDR_W(14), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dut1 (
        .clk(clk), .rst(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hreadyout[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]),
        .sram_ce(sram_ce[1]), .sram_we(sram_we[1]), .sram_be(sram_be[1]),
        .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1])
    );

    // Behavioural SRAM macros: read data appears the cycle after a read ce and holds
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (sram_ce[d]) begin
                if (sram_we[d]) begin
                    for (int b = 0; b < 4; b++)
                        if (sram_be[d][b])
                            mem[d][sram_addr[d]][8*b +: 8] = sram_wdata[d][8*b +: 8];
                end else
                    sram_rdata[d] <= mem[d][sram_addr[d]];
            end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_illegal(input logic [31:0] a, input logic [2:0] s);
        return s > 3'd2 || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00) || a[31:16] != 16'h0;
    endfunction

    function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] s);
        logic [3:0] b;
        case (s)
            3'd0:    b = (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
                         (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
            3'd1:    b = a[1] ? 4'b1100 : 4'b0011;
            default: b = 4'b1111;
        endcase
        return b;
    endfunction

    task automatic add(input logic [31:0] a, input logic [2:0] s, input logic w, input logic [31:0] wd);
        item_t it;
        it.addr = a; it.size = s; it.write = w; it.wdata = wd;
        seq.push_back(it);
    endtask

    task automatic run(input int d);
        int    idx = 0, cyc = 0, waits = 0, ce_n = 0, bad_we = 0, legal = 0;
        int    ws = (d == 0) ? 0 : 2;
        bit    pend = 0, prev_wr;
        item_t it;
        exp_t  e;
        logic [13:0] wa;
        while ((idx < seq.size() || pend) && cyc < 100) begin
            if (idx < seq.size()) begin
                hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = seq[idx].addr;
                hsize[d] = seq[idx].size; hwrite[d] = seq[idx].write;
            end else begin
                hsel[d] = 1'b0; htrans[d] = 2'b00;
            end
            hwdata[d] = (pend && sb[0].write) ? sb[0].wdata : 32'h0;
            @(negedge clk);
            ce_n += int'(sram_ce[d]);
            if (sram_ce[d] && sram_we[d]) begin
                bad_we += int'(!hreadyout[d]);
                check_eq("wr_be", 32'(sram_be[d]), 32'(sb[0].be));
                check_eq("wr_data", sram_wdata[d], sb[0].wdata);
            end
            prev_wr = pend && sb[0].write && !sb[0].resp;
            if (pend) begin
                if (!hreadyout[d]) begin
                    waits++;
                    if (sb[0].resp) check_eq("err1_resp", 32'(hresp[d]), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_eq("hresp", 32'(hresp[d]), 32'(e.resp));
                    check_eq("waits", waits, e.waits);
                    if (!e.write && !e.resp) check_eq("hrdata", hrdata[d], e.rdata);
                    pend = 0;
                end
            end
            if (hreadyout[d] && idx < seq.size()) begin
                it = seq[idx];
                e.write = it.write; e.resp = is_illegal(it.addr, it.size);
                e.be = lanes(it.addr, it.size); e.wdata = it.wdata;
                e.waits = e.resp ? 1 : it.write ? ws : (ws == 0 ? int'(prev_wr) : ws);
                wa = it.addr[15:2];
                if (!e.resp) begin
                    legal++;
                    if (it.write)
                        for (int b = 0; b < 4; b++)
                            if (e.be[b]) ref_w[d][wa][8*b +: 8] = it.wdata[8*b +: 8];
                end
                e.rdata = ref_w[d][wa];
                sb.push_back(e);
                idx++; pend = 1; waits = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("timeout", 32'(idx < seq.size() || pend), 32'd0);
        check_eq("ce_count", ce_n, legal);
        check_eq("we_final", bad_we, 0);
        hsel[d] = 1'b0; htrans[d] = 2'b00;
        seq.delete(); sb.delete();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16384; i++) begin mem[d][i] = 32'h0; ref_w[d][i] = 32'h0; end
            hsel[d] = 1'b0; haddr[d] = 32'h0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
            hsize[d] = 3'd2; hwdata[d] = 32'h0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_hreadyout", 32'(hreadyout[d]), 32'd1);
            check_eq("rst_hresp", 32'(hresp[d]), 32'd0);
            check_eq("rst_hrdata", hrdata[d], 32'h0);
            check_eq("rst_ce", 32'(sram_ce[d]), 32'd0);
            check_eq("rst_we", 32'(sram_we[d]), 32'd0);
            check_eq("rst_be", 32'(sram_be[d]), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        // write then back-to-back read: port conflict
        add(32'h100, 3'd2, 1'b1, 32'hDEADBEEF); add(32'h100, 3'd2, 1'b0, 32'h0); run(0);
        // byte and half lanes
        add(32'h203, 3'd0, 1'b1, 32'hAA00_0000); add(32'h200, 3'd1, 1'b1, 32'h0000_1234);
        add(32'h200, 3'd2, 1'b0, 32'h0); run(0);
        // pipelined zero-wait reads
        add(32'h0, 3'd2, 1'b1, 32'h1111_1111); add(32'h4, 3'd2, 1'b1, 32'h2222_2222);
        add(32'h8, 3'd2, 1'b1, 32'h3333_3333); run(0);
        add(32'h0, 3'd2, 1'b0, 32'h0); add(32'h4, 3'd2, 1'b0, 32'h0); add(32'h8, 3'd2, 1'b0, 32'h0); run(0);
        // illegal transfers, then a legal read following ERR2
        add(32'h101, 3'd1, 1'b0, 32'h0); add(32'h102, 3'd2, 1'b0, 32'h0);
        add(32'h104, 3'd3, 1'b1, 32'h5555_5555); add(32'h1_0000, 3'd2, 1'b1, 32'h6666_6666);
        add(32'h100, 3'd2, 1'b0, 32'h0); run(0);
        // two wait states
        add(32'h40, 3'd2, 1'b1, 32'hCAFE_F00D); add(32'h40, 3'd2, 1'b0, 32'h0);
        add(32'h46, 3'd1, 1'b1, 32'hBEEF_0000); add(32'h41, 3'd0, 1'b1, 32'h0000_7700);
        add(32'h44, 3'd2, 1'b0, 32'h0); add(32'h40, 3'd2, 1'b0, 32'h0); run(1);
        // reset during the write data phase
        hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h300; hwrite[0] = 1'b1; hsize[0] = 3'd2;
        @(posedge clk); #1;
        hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = 32'h1111_1111; rst = 1'b1;
        @(negedge clk);
        check_eq("rst_wr_ce", 32'(sram_ce[0]), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_mem", mem[0][14'h0C0], 32'h0);
        check_eq("post_rst_hreadyout", 32'(hreadyout[0]), 32'd1);
        check_eq("post_rst_hresp", 32'(hresp[0]), 32'd0);
        check_eq("post_rst_hrdata", hrdata[0], 32'h0);
        check_eq("post_rst_ce", 32'(sram_ce[0]), 32'd0);
        check_eq("post_rst_be", 32'(sram_be[0]), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
